// File: rtl/item_spawner.sv
// item_spawner: places a food item on a random in-field cell that is not on the snake body.
// Two free-running Galois LFSRs supply candidates; a sequential scan rejects occupied cells.
module item_spawner #(
  parameter int unsigned GRID_W    = 80,
  parameter int unsigned GRID_H    = 60,
  parameter int unsigned COORD_W   = 7,
  parameter int unsigned MAX_LEN   = 480,
  parameter int unsigned LEN_W     = 9,
  parameter int unsigned MAX_TRIES = 16,
  parameter logic [15:0] SEED_X    = 16'hACE1,
  parameter logic [15:0] SEED_Y    = 16'h1D2B
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Req,
  input  logic [MAX_LEN*COORD_W-1:0] i_Body_x,
  input  logic [MAX_LEN*COORD_W-1:0] i_Body_y,
  input  logic [LEN_W-1:0]           i_Body_size,
  output logic                       o_Busy,
  output logic                       o_Valid,
  output logic                       o_Fail,
  output logic [COORD_W-1:0]         o_Item_x,
  output logic [COORD_W-1:0]         o_Item_y
);

  localparam int unsigned IDX_W = LEN_W + 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [15:0] TAPS       = 16'hB400;
  localparam logic [15:0] SEED_X_EFF = (SEED_X == 16'h0) ? 16'h0001 : SEED_X;
  localparam logic [15:0] SEED_Y_EFF = (SEED_Y == 16'h0) ? 16'h0001 : SEED_Y;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [15:0]        lfsr_x, lfsr_y;
  logic               req_q;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] cand_x_q, cand_y_q;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TRY_W-1:0]   tries, tries_nxt;
  logic [IDX_W-1:0]   size_eff;
  logic [SEL_W-1:0]   seg_sel;
  logic [COORD_W-1:0] seg_x_arr [MAX_LEN];
  logic [COORD_W-1:0] seg_y_arr [MAX_LEN];
  logic               draw_ok, at_end, hit;
  logic               cand_ld, valid_nxt, fail_nxt;

  // Unpack the flat body buses into per-segment coordinates
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_unpack
    assign seg_x_arr[g] = i_Body_x[g*COORD_W +: COORD_W];
    assign seg_y_arr[g] = i_Body_y[g*COORD_W +: COORD_W];
  end

  assign cand_x   = lfsr_x[COORD_W-1:0];
  assign cand_y   = lfsr_y[COORD_W-1:0];
  assign draw_ok  = (32'(cand_x) < GRID_W) && (32'(cand_y) < GRID_H);
  assign size_eff = (32'(i_Body_size) > MAX_LEN) ? IDX_W'(MAX_LEN) : IDX_W'(i_Body_size);
  assign seg_sel  = SEL_W'(idx);
  assign at_end   = (idx == size_eff);
  assign hit      = (seg_x_arr[seg_sel] == cand_x_q) && (seg_y_arr[seg_sel] == cand_y_q);

  // Free-running random sources, stepped every clock regardless of state
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lfsr_x <= SEED_X_EFF;
      lfsr_y <= SEED_Y_EFF;
    end else begin
      lfsr_x <= {1'b0, lfsr_x[15:1]} ^ (lfsr_x[0] ? TAPS : 16'h0000);
      lfsr_y <= {1'b0, lfsr_y[15:1]} ^ (lfsr_y[0] ? TAPS : 16'h0000);
    end
  end

  // Next-state logic: draw, scan the body, retry on collision up to the try limit
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tries_nxt = tries;
    cand_ld   = 1'b0;
    valid_nxt = 1'b0;
    fail_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_q) begin
          state_nxt = S_DRAW;
          idx_nxt   = '0;
          tries_nxt = '0;
        end
      end
      S_DRAW: begin
        if (draw_ok) begin
          cand_ld   = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (at_end) begin
          state_nxt = S_DONE;
          valid_nxt = 1'b1;
        end else if (hit) begin
          tries_nxt = tries + TRY_W'(1);
          if (tries == TRY_LAST) begin
            state_nxt = S_DONE;
            fail_nxt  = 1'b1;
          end else begin
            state_nxt = S_DRAW;
          end
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and candidate latch; the request is registered one cycle ahead of leaving IDLE
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      idx      <= '0;
      tries    <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
    end else begin
      state <= state_nxt;
      req_q <= (state == S_IDLE && !req_q) ? i_Req : 1'b0;
      idx   <= idx_nxt;
      tries <= tries_nxt;
      if (cand_ld) begin
        cand_x_q <= cand_x;
        cand_y_q <= cand_y;
      end
    end
  end

  // Registered outputs: busy flag, result strobes and item position
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Busy   <= 1'b0;
      o_Valid  <= 1'b0;
      o_Fail   <= 1'b0;
      o_Item_x <= '0;
      o_Item_y <= '0;
    end else begin
      o_Busy  <= (state_nxt != S_IDLE);
      o_Valid <= valid_nxt;
      o_Fail  <= fail_nxt;
      if (valid_nxt) begin
        o_Item_x <= cand_x_q;
        o_Item_y <= cand_y_q;
      end
    end
  end

endmodule

// File: doc/item_spawner.md
# item_spawner

Parametrised food-item placer for the snake game. On request, it draws pseudo-random grid coordinates and rejects any draw outside the play field. It then scans the snake body segment by segment and rejects draws that land exactly on an occupied cell. The result is a registered item position with a one-cycle valid strobe, or a fail strobe after a bounded number of collisions. It sits between the game-control FSM, which issues requests, and the renderer/collision logic, which consume the item position.

## Interface
- GRID_W, 80: play-field width in cells; legal x is 0..GRID_W-1.
- GRID_H, 60: play-field height in cells; legal y is 0..GRID_H-1.
- COORD_W, 7: coordinate width; 2^COORD_W ≥ max(GRID_W, GRID_H).
- MAX_LEN, 480: maximum body segments; sets the bus width.
- LEN_W, 9: width of the body-size input.
- MAX_TRIES, 16: body collisions tolerated before reporting failure.
- SEED_X, 16'hACE1: reset seed of the x LFSR. A value of 0 is replaced by 1.
- SEED_Y, 16'h1D2B: reset seed of the y LFSR. A value of 0 is replaced by 1.

Ports:
- i_Clk, in, 1: the single clock.
- i_Rst, in, 1: asynchronous reset, active-high.
- i_Req, in, 1: request a new item. Sampled only in IDLE.
- i_Body_x, in, MAX_LEN*COORD_W: segment k x-coordinate at bits [k*COORD_W +: COORD_W].
- i_Body_y, in, MAX_LEN*COORD_W: segment k y-coordinate, same packing as i_Body_x.
- i_Body_size, in, LEN_W: number of valid segments. Values above MAX_LEN are treated as MAX_LEN.
- o_Busy, out, 1: high in every state except IDLE.
- o_Valid, out, 1: one-cycle strobe; a new o_Item_x/o_Item_y is available.
- o_Fail, out, 1: one-cycle strobe; no free cell was found within MAX_TRIES collisions.
- o_Item_x, out, COORD_W: registered item x.
- o_Item_y, out, COORD_W: registered item y.

## Operation
Random source:
- There are two independent 16-bit Galois LFSRs, polynomial x^16+x^14+x^13+x^11+1.
- Both LFSRs step every clock, in every state.
- The candidate is the low COORD_W bits of each LFSR.

State machine, states IDLE, DRAW, CHECK, DONE:
- IDLE: when i_Req=1, clear the try count and the index, then go to DRAW. Otherwise stay in IDLE.
- DRAW: if cand_x<GRID_W and cand_y<GRID_H, latch the candidate, clear the index, and go to CHECK. Otherwise stay in DRAW; the LFSRs advance and the next draw is taken.
- CHECK, comparing segment index idx:
  - If idx == effective size, go to DONE with fail=0.
  - Otherwise, if body_x[idx]==cand_x AND body_y[idx]==cand_y, increment tries:
    - If tries reaches MAX_TRIES, go to DONE with fail=1.
    - Otherwise go back to DRAW.
  - Otherwise increment idx and stay in CHECK.
- A collision requires both coordinates to match. Sharing only the row or only the column is not a collision.
- DONE: lasts exactly one cycle, then returns to IDLE.
  - fail=0: o_Valid=1, and o_Item_x/o_Item_y are loaded with the candidate.
  - fail=1: o_Fail=1, and the item outputs keep their previous value.

Other rules:
- i_Req is ignored while o_Busy=1; requests are not queued.
- The caller holds i_Body_x, i_Body_y and i_Body_size stable while o_Busy=1.
- Counter widths: idx is LEN_W+1 bits; tries is clog2(MAX_TRIES+1) bits.

Reset:
- State goes to IDLE; o_Busy, o_Valid, o_Fail, o_Item_x and o_Item_y go to 0.
- The LFSRs load SEED_X and SEED_Y; the counters clear.
- Reset asserted mid-operation aborts the operation immediately. No strobe is issued.

## Timing
- i_Req is sampled high at edge k. DRAW occupies cycle k+1.
- First-draw acceptance: CHECK occupies cycles k+2 .. k+2+N, where N is the effective size.
- DONE, with its strobe, is the cycle following edge k+3+N.
- Minimum latency is therefore N+3 clocks. Each out-of-range draw adds 1 cycle. Each collision adds (index reached + 2) cycles.
- N=0: one CHECK cycle, then DONE. Latency is 3.
- o_Valid and o_Fail are never high together, and never high on consecutive cycles for the same request.
- o_Item_x/o_Item_y change only at the edge that starts a valid DONE.
- o_Busy goes high at edge k+1 and low at the edge leaving DONE.
- A new i_Req can be accepted at the first IDLE cycle after DONE.

## Test plan
- Empty body: reset, i_Body_size=0, pulse i_Req. Require o_Valid exactly 3 cycles after the req edge, o_Item_x<80 and o_Item_y<60, and o_Fail=0.
- Range sweep: 1000 back-to-back requests with size 0 and default grid. Require every output x<80 and y<60, and no o_Fail.
- Exact-match rule: GRID_W=GRID_H=4, body occupying all cells except (2,1), size=15. Require every successful item to be (2,1). Also require that row-only or column-only matches are accepted.
- Full grid: GRID_W=GRID_H=2, body={(0,0),(0,1),(1,0),(1,1)}, MAX_TRIES=16. Require exactly one o_Fail strobe, o_Valid never asserted, and o_Item unchanged from its prior value.
- Busy handling: pulse i_Req again 2 cycles after an accepted request with size=10. Require a single o_Valid strobe and o_Busy low one cycle after it.
- Reset mid-CHECK: assert i_Rst during CHECK at idx=5. Require all outputs 0 immediately with no strobe, and the same first result as after a cold reset when the same stimulus is replayed.
